eq_band_mixer: RTL and testbench
================================

EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 SHALL have parameter N_BAND, default 5, the number of equalizer bands summed.
REQ-002 SHALL have parameter GAIN_W, default 16, the gain width (unsigned Q2.14; 0x4000 = unity).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port band_valid  input  1  one-cycle pulse; all band_in lanes valid.
REQ-006 SHALL have port band_in  input  N_BAND*16  packed signed band outputs; lane k = bits [16k+15:16k].
REQ-007 SHALL have port gain_wr  input  1  gain register write strobe.
REQ-008 SHALL have port gain_addr  input  3  band index for the write.
REQ-009 SHALL have port gain_data  input  GAIN_W  gain value to write.
REQ-010 SHALL have port y_out  output  16  signed mixed sample.
REQ-011 SHALL have port y_valid  output  1  one-cycle pulse; y_out updated.
REQ-012 SHALL have port sat_flag  output  1  clip indicator, asserted only together with y_valid.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse; band_valid dropped.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 SHALL have port sat_count  output  16  saturation event count (see Configuration).

Function
REQ-016 SHALL implement the FSM states IDLE, MAC and ROUND, encoded with localparams.
REQ-017 In IDLE, band_valid SHALL latch all band_in lanes, copy shadow gains to active gains, clear the accumulator, set band index 0 and go to MAC.
REQ-018 MAC SHALL use one shared 17x16 signed multiplier (gain zero-extended) and perform one band per cycle: acc += band[idx]*gain[idx], idx 0..N_BAND-1, then go to ROUND.
REQ-019 The accumulator SHALL be 16+GAIN_W+ceil(log2(N_BAND))+1 bits (36 at default), signed, so it never wraps.
REQ-020 ROUND SHALL compute (acc + 2^13) >>> 14 (round half up), clamp to [-32768, 32767], register y_out, pulse y_valid, set sat_flag if clamped, then go to IDLE.
REQ-021 Latency SHALL be exactly N_BAND+1 rising edges from the edge sampling band_valid to the edge that asserts y_valid (6 at default).
REQ-022 band_valid while busy SHALL be ignored for data and SHALL pulse overrun on the next edge; the in-flight sample SHALL complete unaffected.
REQ-023 gain_wr SHALL write shadow gain[gain_addr] in any state; addresses >= N_BAND SHALL be ignored; a write during MAC/ROUND SHALL take effect only at the next capture.
REQ-024 gain_wr and band_valid on the same edge in IDLE: the capture SHALL use the old shadow value.
REQ-025 y_out SHALL hold its last value between y_valid pulses.

Reset
REQ-026 rst_n low SHALL force IDLE, y_out=0, y_valid=0, sat_flag=0, overrun=0, busy=0, sat_count=0, accumulator=0, all shadow and active gains=0x4000.
REQ-027 Reset asserted mid-MAC or mid-ROUND SHALL abort the sample; no y_valid SHALL follow release.

Configuration
REQ-028 With macro EQ_MIXER_SAT_COUNT_EN defined, sat_count SHALL increment on each y_valid with sat_flag=1, saturating at 0xFFFF.
REQ-029 Without EQ_MIXER_SAT_COUNT_EN, sat_count SHALL be tied to 0 and the counter SHALL not be synthesized; the port list SHALL be unchanged.

Structure
REQ-030 Package eq_pkg SHALL hold SAMPLE_W=16, GAIN_UNITY=16'h4000, the Q-format shift 14 and the FSM state encoding.
REQ-031 Saturation/rounding SHALL be a sub-module eq_round_sat (acc in, 16-bit out, clip flag), instantiated once.

Verification
REQ-032 Only gain[2]=0x4000 (others written 0), all lanes 0x1000 -> y_out=0x1000, sat_flag=0, y_valid exactly 6 edges after band_valid.
REQ-033 Reset gains, all lanes 0x2000 -> sum 0xA000 clamps to y_out=0x7FFF, sat_flag=1; all lanes 0x8000 -> y_out=0x8000, sat_flag=1; sat_count=2 only with EQ_MIXER_SAT_COUNT_EN.
REQ-034 Lane0=3, gain[0]=0x2000, others gain 0 -> y_out=2 (1.5 rounds up); lane0=-3 -> y_out=-1.
REQ-035 Second band_valid 2 cycles after the first -> overrun pulses once, a single y_valid occurs, and y_out reflects the first sample only.
REQ-036 gain_wr gain[0]=0 during MAC -> current y_out uses the old gain; the next sample uses 0. rst_n low at MAC cycle 3 -> no y_valid, all outputs 0.

Source files
------------

// File: rtl/eq_band_mixer_pkg.sv
// Shared constants and FSM encoding for the equalizer band mixer.
//   SAMPLE_W   : audio sample width (signed)
//   GAIN_UNITY : Q2.14 unity gain, reset value of every gain register
//   Q_SHIFT    : fractional bits of the gain format
//   state_e    : mixer FSM states
package eq_pkg;

  localparam int          SAMPLE_W   = 16;
  localparam logic [15:0] GAIN_UNITY = 16'h4000;
  localparam int          Q_SHIFT    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } state_e;

endpackage

// File: rtl/eq_band_mixer_round_sat.sv
// eq_round_sat: round-half-up Q-format reduction of the mixer accumulator
// followed by saturation to a signed 16-bit sample.
//   acc  : signed accumulator (ACC_W bits)
//   y    : rounded, clamped sample
//   clip : high when the rounded value fell outside the 16-bit range
module eq_round_sat
  import eq_pkg::*;
#(
  parameter int ACC_W = 36
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic        [SAMPLE_W-1:0] y,
  output logic                       clip
);

  localparam logic [ACC_W-1:0] HALF =
    {{(ACC_W-Q_SHIFT){1'b0}}, 1'b1, {(Q_SHIFT-1){1'b0}}};

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic                    fits;

  always_comb begin
    biased  = acc + HALF;
    shifted = biased >>> Q_SHIFT;
    // Value fits when every bit from the 16-bit sign position upward agrees.
    fits    = (&shifted[ACC_W-1:SAMPLE_W-1]) || (~|shifted[ACC_W-1:SAMPLE_W-1]);
    clip    = ~fits;
    if (fits) begin
      y = shifted[SAMPLE_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      y = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      y = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: gain-weighted sum of N_BAND equalizer band outputs using a
// single shared multiplier (one band per cycle), then round and saturate.
//   clk, rst_n          : clock, asynchronous active-low reset
//   band_valid, band_in : input sample strobe and packed signed band lanes
//   gain_wr/addr/data   : shadow gain register write port (Q2.14, unsigned)
//   y_out, y_valid      : mixed sample and its one-cycle strobe
//   sat_flag            : clip indicator, valid with y_valid
//   overrun             : pulse when band_valid arrives while busy
//   busy                : FSM not in IDLE
//   sat_count           : saturation event counter
// Optional feature: define EQ_MIXER_SAT_COUNT_EN to build the saturation
// counter; otherwise sat_count is tied to zero.
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int N_BAND = 5,
  parameter int GAIN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       band_valid,
  input  logic [N_BAND*SAMPLE_W-1:0] band_in,
  input  logic                       gain_wr,
  input  logic [2:0]                 gain_addr,
  input  logic [GAIN_W-1:0]          gain_data,
  output logic [SAMPLE_W-1:0]        y_out,
  output logic                       y_valid,
  output logic                       sat_flag,
  output logic                       overrun,
  output logic                       busy,
  output logic [15:0]                sat_count
);

  localparam int IDX_W  = (N_BAND > 1) ? $clog2(N_BAND) : 1;
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(N_BAND) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  state_e                    state_q, state_d;
  logic [SAMPLE_W-1:0]       lanes_q  [N_BAND];
  logic [SAMPLE_W-1:0]       lanes_d  [N_BAND];
  logic [GAIN_W-1:0]         shadow_q [N_BAND];
  logic [GAIN_W-1:0]         shadow_d [N_BAND];
  logic [GAIN_W-1:0]         active_q [N_BAND];
  logic [GAIN_W-1:0]         active_d [N_BAND];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SAMPLE_W-1:0]       y_out_q, y_out_d;
  logic                      y_valid_q, y_valid_d;
  logic                      sat_flag_q, sat_flag_d;
  logic                      overrun_q, overrun_d;

  logic signed [GAIN_W:0]    gain_ext;
  logic signed [SAMPLE_W-1:0] lane_sel;
  logic signed [PROD_W-1:0]  prod;
  logic [SAMPLE_W-1:0]       rs_y;
  logic                      rs_clip;

  // Shared multiplier: gain is zero-extended so it is never negative.
  assign gain_ext = signed'({1'b0, active_q[idx_q]});
  assign lane_sel = signed'(lanes_q[idx_q]);
  assign prod     = gain_ext * lane_sel;

  eq_round_sat #(
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc  (acc_q),
    .y    (rs_y),
    .clip (rs_clip)
  );

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    y_out_d    = y_out_q;
    y_valid_d  = 1'b0;
    sat_flag_d = 1'b0;
    overrun_d  = 1'b0;

    // Capture below reads shadow_q, so a same-edge write is not yet visible.
    if (gain_wr && (int'(gain_addr) < N_BAND)) begin
      shadow_d[gain_addr] = gain_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (band_valid) begin
          for (int unsigned k = 0; k < N_BAND; k++) begin
            lanes_d[k] = band_in[k*SAMPLE_W +: SAMPLE_W];
          end
          active_d = shadow_q;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        overrun_d = band_valid;
        acc_d     = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        if (idx_q == IDX_W'(N_BAND - 1)) begin
          state_d = ST_ROUND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ROUND: begin
        overrun_d  = band_valid;
        y_out_d    = rs_y;
        y_valid_d  = 1'b1;
        sat_flag_d = rs_clip;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int unsigned k = 0; k < N_BAND; k++) begin
        lanes_q[k]  <= '0;
        shadow_q[k] <= GAIN_W'(GAIN_UNITY);
        active_q[k] <= GAIN_W'(GAIN_UNITY);
      end
      acc_q      <= '0;
      idx_q      <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      sat_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      y_out_q    <= y_out_d;
      y_valid_q  <= y_valid_d;
      sat_flag_q <= sat_flag_d;
      overrun_q  <= overrun_d;
    end
  end

  assign y_out    = y_out_q;
  assign y_valid  = y_valid_q;
  assign sat_flag = sat_flag_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef EQ_MIXER_SAT_COUNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Counts on the same edge that raises y_valid with sat_flag.
  always_comb begin
    sat_count_d = sat_count_q;
    if ((state_q == ST_ROUND) && rs_clip && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_eq_band_mixer.sv
module tb_eq_band_mixer;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          band_valid;
  logic [79:0]   band_in;
  logic          gain_wr;
  logic [2:0]    gain_addr;
  logic [15:0]   gain_data;
  logic [15:0]   y_out;
  logic          y_valid;
  logic          sat_flag;
  logic          overrun;
  logic          busy;
  logic [15:0]   sat_count;

  int errors = 0;
  int checks = 0;

  int unsigned shadow_m [NB];
  int          sat_events_m = 0;

  eq_band_mixer #(
    .N_BAND (5),
    .GAIN_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .band_valid (band_valid),
    .band_in    (band_in),
    .gain_wr    (gain_wr),
    .gain_addr  (gain_addr),
    .gain_data  (gain_data),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .sat_flag   (sat_flag),
    .overrun    (overrun),
    .busy       (busy),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  // Reference: exact sum of lane*gain, round half up by 2^14, clamp to int16.
  function automatic void model(input logic [79:0] bus, input int unsigned g [NB],
                                output logic [15:0] y, output logic sat);
    longint acc = 0;
    longint r;
    for (int k = 0; k < NB; k++) begin
      logic signed [15:0] lane;
      lane = bus[k*16 +: 16];
      acc += longint'(lane) * longint'(g[k]);
    end
    r = (acc + 8192) >>> 14;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    if (r < -32768) begin r = -32768; sat = 1'b1; end
    y = 16'(r);
  endfunction

  function automatic int sat_count_exp();
`ifdef EQ_MIXER_SAT_COUNT_EN
    return (sat_events_m > 65535) ? 65535 : sat_events_m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [79:0] fill(input logic [15:0] v);
    return {v, v, v, v, v};
  endfunction

  task automatic write_gain(input int addr, input int unsigned data);
    @(negedge clk);
    gain_wr   = 1'b1;
    gain_addr = 3'(addr);
    gain_data = 16'(data);
    @(negedge clk);
    gain_wr = 1'b0;
    if (addr < NB) shadow_m[addr] = data;
  endtask

  // Pulses band_valid and returns the edge count to y_valid (-1 on timeout).
  task automatic run_sample(input logic [79:0] bus, output int lat,
                            output logic [15:0] y, output logic sat);
    @(negedge clk);
    band_valid = 1'b1;
    band_in    = bus;
    @(negedge clk);
    band_valid = 1'b0;
    lat = -1;
    y   = 'x;
    sat = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (y_valid) begin
        lat = k;
        y   = y_out;
        sat = sat_flag;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) shadow_m[k] = 32'h4000;
    sat_events_m = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({y_out, y_valid, sat_flag, overrun, busy} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: y_out=%h y_valid=%b sat=%b ovr=%b busy=%b, required all 0",
               y_out, y_valid, sat_flag, overrun, busy);
    end
    checks++;
    if (sat_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_sat_count: got %h, required 0000", sat_count);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] y, ey; logic s, es;
    run_sample(fill(16'h2000), lat, y, s);
    model(fill(16'h2000), shadow_m, ey, es);
    if (es) sat_events_m++;
    checks++;
    if (y !== 16'h7FFF || s !== 1'b1 || ey !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos: y=%h sat=%b, required 7fff/1", y, s);
    end
    run_sample(fill(16'h8000), lat, y, s);
    model(fill(16'h8000), shadow_m, ey, es);
    if (es) sat_events_m++;
    checks++;
    if (y !== 16'h8000 || s !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: y=%h sat=%b, required 8000/1", y, s);
    end
    checks++;
    if (sat_count !== 16'(sat_count_exp())) begin
      errors++;
      $display("FAIL sat_count: got %0d, required %0d", sat_count, sat_count_exp());
    end
  endtask

  task automatic test_single_band();
    int lat; logic [15:0] y; logic s;
    for (int k = 0; k < NB; k++) write_gain(k, (k == 2) ? 32'h4000 : 0);
    @(negedge clk);
    band_valid = 1'b1;
    band_in    = fill(16'h1000);
    @(negedge clk);
    band_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_capture: got %b, required 1", busy);
    end
    lat = -1; y = 'x; s = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (y_valid) begin lat = k; y = y_out; s = sat_flag; break; end
    end
    checks++;
    if (lat != NB + 1) begin
      errors++;
      $display("FAIL latency: got %0d edges, required %0d", lat, NB + 1);
    end
    checks++;
    if (y !== 16'h1000 || s !== 1'b0) begin
      errors++;
      $display("FAIL single_band: y=%h sat=%b, required 1000/0", y, s);
    end
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0 || y_out !== 16'h1000) begin
      errors++;
      $display("FAIL hold: y_valid=%b y_out=%h, required 0/1000", y_valid, y_out);
    end
  endtask

  task automatic test_rounding();
    int lat; logic [15:0] y; logic s;
    write_gain(0, 32'h2000);
    write_gain(2, 0);
    run_sample({16'h7123, 16'h1111, 16'h8000, 16'h5555, 16'd3}, lat, y, s);
    checks++;
    if (y !== 16'd2 || s !== 1'b0) begin
      errors++;
      $display("FAIL round_pos: y=%h sat=%b, required 0002/0", y, s);
    end
    run_sample({16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFD}, lat, y, s);
    checks++;
    if (y !== 16'hFFFF || s !== 1'b0) begin
      errors++;
      $display("FAIL round_neg: y=%h sat=%b, required ffff/0", y, s);
    end
  endtask

  task automatic test_overrun();
    logic [79:0] d1, d2; logic [15:0] ey, y; logic es;
    int nvalid = 0, novr = 0;
    for (int k = 0; k < NB; k++) write_gain(k, 32'h4000);
    d1 = {16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    d2 = fill(16'h0ABC);
    model(d1, shadow_m, ey, es);
    @(negedge clk); band_valid = 1'b1; band_in = d1;
    @(negedge clk); band_valid = 1'b0;
    @(negedge clk); band_valid = 1'b1; band_in = d2;
    @(negedge clk); band_valid = 1'b0;
    y = 'x;
    if (overrun) novr++;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (overrun) novr++;
      if (y_valid) begin nvalid++; y = y_out; end
    end
    checks++;
    if (novr != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, required 1", novr);
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL overrun_valids: got %0d, required 1", nvalid);
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL overrun_data: y=%h, required %h", y, ey);
    end
  endtask

  task automatic test_gain_timing();
    logic [79:0] d; logic [15:0] ey, y; logic es, s;
    int unsigned snap [NB];
    int lat;
    d = {16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h1234};
    snap = shadow_m;
    model(d, snap, ey, es);
    @(negedge clk); band_valid = 1'b1; band_in = d;
    @(negedge clk); band_valid = 1'b0;
    gain_wr = 1'b1; gain_addr = 3'd0; gain_data = 16'h0000;
    @(negedge clk); gain_wr = 1'b0;
    shadow_m[0] = 0;
    lat = -1; y = 'x;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (y_valid) begin lat = k; y = y_out; break; end
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL gain_wr_mid_mac: y=%h, required %h (old gain)", y, ey);
    end
    model(d, shadow_m, ey, es);
    run_sample(d, lat, y, s);
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL gain_next_sample: y=%h, required %h", y, ey);
    end
    // Write and capture on the same edge: capture sees the old shadow value.
    snap = shadow_m;
    model(d, snap, ey, es);
    @(negedge clk);
    band_valid = 1'b1; band_in = d;
    gain_wr = 1'b1; gain_addr = 3'd1; gain_data = 16'h1000;
    @(negedge clk);
    band_valid = 1'b0; gain_wr = 1'b0;
    shadow_m[1] = 32'h1000;
    y = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (y_valid) begin y = y_out; break; end
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL same_edge_capture: y=%h, required %h", y, ey);
    end
  endtask

  task automatic test_reset_mid_mac();
    int nvalid = 0;
    @(negedge clk); band_valid = 1'b1; band_in = fill(16'h7000);
    @(negedge clk); band_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) shadow_m[k] = 32'h4000;
    sat_events_m = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (y_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL reset_abort_valid: got %0d y_valid pulses, required 0", nvalid);
    end
    checks++;
    if ({y_out, sat_flag, overrun, busy, sat_count} !== 35'h0) begin
      errors++;
      $display("FAIL reset_abort_outputs: y_out=%h sat=%b ovr=%b busy=%b cnt=%h, required all 0",
               y_out, sat_flag, overrun, busy, sat_count);
    end
  endtask

  task automatic test_random();
    logic [79:0] d; logic [15:0] ey, y; logic es, s;
    int lat;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < 2; w++) begin
        write_gain(int'($urandom_range(0, 7)), $urandom_range(0, 16'hFFFF));
      end
      d = {$urandom(), $urandom(), $urandom()};
      if (it % 4 == 0) d = fill(16'($urandom_range(0, 16'hFFFF)));
      model(d, shadow_m, ey, es);
      if (es) sat_events_m++;
      run_sample(d, lat, y, s);
      checks++;
      if (lat != NB + 1 || y !== ey || s !== es) begin
        errors++;
        $display("FAIL random[%0d]: lat=%0d y=%h sat=%b, required lat=%0d y=%h sat=%b",
                 it, lat, y, s, NB + 1, ey, es);
      end
    end
    checks++;
    if (sat_count !== 16'(sat_count_exp())) begin
      errors++;
      $display("FAIL random_sat_count: got %0d, required %0d", sat_count, sat_count_exp());
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    band_valid = 1'b0;
    band_in    = '0;
    gain_wr    = 1'b0;
    gain_addr  = '0;
    gain_data  = '0;
    test_reset();
    test_saturation();
    test_single_band();
    test_rounding();
    test_overrun();
    test_gain_timing();
    test_reset_mid_mac();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
